// File: rtl/bip2_control_unit.sv
// BIP2 multi-cycle control unit: fetch/decode/memory-read/execute sequencer.
// Control strobes are Moore decodes of state and IR; only EXEC branches look at the flags.
module bip2_control_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  run_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  z_flag_in,
  input  logic                  n_flag_in,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic                  pc_inc_out,
  output logic                  pc_load_out,
  output logic                  mem_rd_out,
  output logic                  mem_wr_out,
  output logic                  acc_load_out,
  output logic [1:0]            acc_sel_out,
  output logic                  alu_op_out,
  output logic                  alu_src_out,
  output logic                  halted_out,
  output logic [2:0]            state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_MEMRD  = 3'b011,
    S_EXEC   = 3'b100,
    S_HALT   = 3'b101
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_ir;
  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic                    w_is_branch;
  logic                    w_taken;

  assign w_opcode  = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_out    = r_ir;
  assign state_out = r_state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (run_in) r_state <= S_FETCH;
        S_FETCH: begin
          r_ir    <= instr_in;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_opcode == OP_HLT)
            r_state <= S_HALT;
          else if (w_opcode == OP_LD || w_opcode == OP_ADD || w_opcode == OP_SUB)
            r_state <= S_MEMRD;
          else
            r_state <= S_EXEC;
        end
        S_MEMRD:  r_state <= S_EXEC;
        S_EXEC:   r_state <= run_in ? S_FETCH : S_IDLE;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_is_branch = 1'b1;
    w_taken     = 1'b0;
    case (w_opcode)
      OP_BEQ:  w_taken = z_flag_in;
      OP_BNE:  w_taken = !z_flag_in;
      OP_BGT:  w_taken = !z_flag_in && !n_flag_in;
      OP_BGE:  w_taken = !n_flag_in;
      OP_BLT:  w_taken = n_flag_in;
      OP_BLE:  w_taken = n_flag_in || z_flag_in;
      default: w_is_branch = 1'b0;
    endcase
  end

  always_comb begin
    pc_inc_out   = 1'b0;
    pc_load_out  = 1'b0;
    mem_rd_out   = 1'b0;
    mem_wr_out   = 1'b0;
    acc_load_out = 1'b0;
    acc_sel_out  = 2'b00;
    alu_op_out   = 1'b0;
    alu_src_out  = 1'b0;
    halted_out   = 1'b0;
    case (r_state)
      S_MEMRD: mem_rd_out = 1'b1;
      S_HALT:  halted_out = 1'b1;
      S_EXEC: begin
        if (w_is_branch) begin
          pc_load_out = w_taken;
          pc_inc_out  = !w_taken;
        end else begin
          case (w_opcode)
            OP_STO: begin
              mem_wr_out = 1'b1;
              pc_inc_out = 1'b1;
            end
            OP_LD: begin
              acc_load_out = 1'b1;
              pc_inc_out   = 1'b1;
            end
            OP_LDI: begin
              acc_load_out = 1'b1;
              acc_sel_out  = 2'b10;
              pc_inc_out   = 1'b1;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
              acc_load_out = 1'b1;
              acc_sel_out  = 2'b01;
              alu_op_out   = (w_opcode == OP_SUB) || (w_opcode == OP_SUBI);
              alu_src_out  = (w_opcode == OP_ADDI) || (w_opcode == OP_SUBI);
              pc_inc_out   = 1'b1;
            end
            OP_JMP:  pc_load_out = 1'b1;
            default: pc_inc_out  = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bip2_control_unit.sv
// Bench for bip2_control_unit: directed literal checks plus a randomized run
// compared every cycle against a per-instruction phase-plan model.
module tb_bip2_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, run, z, n;
  logic [15:0] instr;
  logic [15:0] ir_out;
  logic        pc_inc, pc_load, mem_rd, mem_wr, acc_load, alu_op, alu_src, halted;
  logic [1:0]  acc_sel;
  logic [2:0]  state_out;
  logic [9:0]  strb;

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] INC     = 10'h200;
  localparam logic [9:0] LOAD    = 10'h100;
  localparam logic [9:0] RD      = 10'h080;
  localparam logic [9:0] WR      = 10'h040;
  localparam logic [9:0] ACC     = 10'h020;
  localparam logic [9:0] SEL_IMM = 10'h010;
  localparam logic [9:0] SEL_ALU = 10'h008;
  localparam logic [9:0] ALU_SUB = 10'h004;
  localparam logic [9:0] ALU_IMM = 10'h002;
  localparam logic [9:0] HLT     = 10'h001;

  always #5 clk = ~clk;

  bip2_control_unit #(.DATA_WIDTH(16), .OPCODE_WIDTH(5)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .run_in(run), .instr_in(instr),
    .z_flag_in(z), .n_flag_in(n), .ir_out(ir_out),
    .pc_inc_out(pc_inc), .pc_load_out(pc_load), .mem_rd_out(mem_rd),
    .mem_wr_out(mem_wr), .acc_load_out(acc_load), .acc_sel_out(acc_sel),
    .alu_op_out(alu_op), .alu_src_out(alu_src), .halted_out(halted),
    .state_out(state_out)
  );

  assign strb = {pc_inc, pc_load, mem_rd, mem_wr, acc_load, acc_sel, alu_op, alu_src, halted};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the current phase letter plus the phases still owed by the instruction in IR.
  logic [7:0]  m_ph   = "I";
  logic [23:0] m_rest = '0;
  logic [15:0] m_ir   = '0;

  function automatic logic [23:0] plan_for(input logic [4:0] op);
    if (op == 5'd0) return {"D", "H", 8'h00};
    if (op == 5'd2 || op == 5'd4 || op == 5'd6) return {"D", "M", "E"};
    return {"D", "E", 8'h00};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= "I";
      m_rest <= '0;
      m_ir   <= '0;
    end else begin
      case (m_ph)
        "I": if (run) m_ph <= "F";
        "F": begin
          m_ir   <= instr;
          m_ph   <= plan_for(instr[15:11])[23:16];
          m_rest <= {plan_for(instr[15:11])[15:0], 8'h00};
        end
        "D", "M": begin
          m_ph   <= m_rest[23:16];
          m_rest <= {m_rest[15:0], 8'h00};
        end
        "E": m_ph <= run ? "F" : "I";
        default: ;
      endcase
    end
  end

  function automatic logic [2:0] exp_state(input logic [7:0] ph);
    case (ph)
      "F": return 3'd1;
      "D": return 3'd2;
      "M": return 3'd3;
      "E": return 3'd4;
      "H": return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [9:0] exp_strobes(input logic [7:0] ph, input logic [15:0] ir,
                                             input logic zf, input logic nf);
    int  op;
    bit  taken;
    op = int'(ir[15:11]);
    if (ph == "M") return RD;
    if (ph == "H") return HLT;
    if (ph != "E") return '0;
    if (op == 1) return WR | INC;
    if (op == 2) return ACC | INC;
    if (op == 3) return ACC | SEL_IMM | INC;
    if (op >= 4 && op <= 7)
      return ACC | SEL_ALU | INC | ((op >= 6) ? ALU_SUB : 10'h0) | ((op % 2 == 1) ? ALU_IMM : 10'h0);
    if (op >= 8 && op <= 13) begin
      case (op)
        8:       taken = zf;
        9:       taken = !zf;
        10:      taken = !zf && !nf;
        11:      taken = !nf;
        12:      taken = nf;
        default: taken = nf || zf;
      endcase
      return taken ? LOAD : INC;
    end
    if (op == 14) return LOAD;
    return INC;
  endfunction

  always @(negedge clk) begin
    check("model_state", state_out, exp_state(m_ph));
    check("model_strobes", strb, exp_strobes(m_ph, m_ir, z, n));
    check("model_ir", ir_out, m_ir);
    check("inc_load_excl", pc_inc & pc_load, 0);
  end

  task automatic cyc(input string nm, input logic [2:0] st, input logic [9:0] sb);
    @(negedge clk);
    #1;
    check({nm, "_state"}, state_out, st);
    check({nm, "_strobes"}, strb, sb);
  endtask

  initial begin
    logic [3:0] bgt_t;
    logic [3:0] ble_t;
    logic [1:0] zn;
    logic [4:0] op;
    logic       taken;
    bgt_t = 4'b0001;
    ble_t = 4'b1110;
    rst_n = 1'b0; run = 1'b1; instr = 16'h1805; z = 1'b0; n = 1'b0;

    cyc("rst0", 3'd0, '0);
    cyc("rst1", 3'd0, '0);
    rst_n = 1'b1;
    cyc("ldi_f", 3'd1, '0);
    cyc("ldi_d", 3'd2, '0);
    check("ldi_ir", ir_out, 16'h1805);
    instr = 16'h2002;
    cyc("ldi_e", 3'd4, ACC | SEL_IMM | INC);

    cyc("add_f", 3'd1, '0);
    cyc("add_d", 3'd2, '0);
    instr = 16'h3803;
    cyc("add_m", 3'd3, RD);
    cyc("add_e", 3'd4, ACC | SEL_ALU | INC);

    cyc("subi_f", 3'd1, '0);
    cyc("subi_d", 3'd2, '0);
    instr = 16'h4010; z = 1'b1;
    cyc("subi_e", 3'd4, ACC | SEL_ALU | ALU_SUB | ALU_IMM | INC);

    cyc("beq1_f", 3'd1, '0);
    cyc("beq1_d", 3'd2, '0);
    cyc("beq1_e", 3'd4, LOAD);
    cyc("beq0_f", 3'd1, '0);
    cyc("beq0_d", 3'd2, '0);
    z = 1'b0;
    cyc("beq0_e", 3'd4, INC);

    for (int i = 0; i < 8; i++) begin
      op    = (i < 4) ? 5'b01010 : 5'b01101;
      zn    = 2'(i);
      instr = {op, 11'h010};
      z = zn[1]; n = zn[0];
      taken = (i < 4) ? bgt_t[zn] : ble_t[zn];
      cyc("br_f", 3'd1, '0);
      cyc("br_d", 3'd2, '0);
      cyc((i < 4) ? "bgt_e" : "ble_e", 3'd4, taken ? LOAD : INC);
    end

    instr = 16'h0804;
    cyc("sto_f", 3'd1, '0);
    cyc("sto_d", 3'd2, '0);
    run = 1'b0;
    cyc("sto_e", 3'd4, WR | INC);
    cyc("sto_idle0", 3'd0, '0);
    cyc("sto_idle1", 3'd0, '0);

    instr = 16'h0000; run = 1'b1;
    cyc("hlt_f", 3'd1, '0);
    cyc("hlt_d", 3'd2, '0);
    cyc("hlt_h", 3'd5, HLT);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      cyc("hlt_sticky", 3'd5, HLT);
    end

    rst_n = 1'b0;
    cyc("rst2", 3'd0, '0);
    rst_n = 1'b1; run = 1'b1; instr = 16'h7005;
    cyc("jmp_f", 3'd1, '0);
    cyc("jmp_d", 3'd2, '0);
    cyc("jmp_e", 3'd4, LOAD);
    rst_n = 1'b0;
    #1;
    check("arst_state", state_out, 3'd0);
    check("arst_strobes", strb, '0);
    check("arst_ir", ir_out, 16'h0000);
    cyc("arst_hold", 3'd0, '0);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      run   = ($urandom_range(0, 9) != 0);
      z     = 1'($urandom);
      n     = 1'($urandom);
      op    = ($urandom_range(0, 24) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      instr = {op, 11'($urandom)};
      rst_n = ($urandom_range(0, 49) != 0);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip2_control_unit.md
Name: bip2_control_unit

Overview:
Multi-cycle control FSM for the BIP2 processor. Fetches the 16-bit instruction word and latches it into an internal IR. Decodes the 5-bit opcode and sequences the datapath: PC, data memory, ALU, and the 3-input accumulator-source mux (memory data / ALU result / immediate). Sits between instruction memory, the status flags and the datapath control inputs.

Parameters:
DATA_WIDTH, 16, instruction word width; opcode is bits [15:11], operand is bits [10:0]
OPCODE_WIDTH, 5, opcode field width

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
run_in  input  1  start/continue execution
instr_in  input  DATA_WIDTH  instruction memory read data for the current PC (valid combinationally)
z_flag_in  input  1  status zero flag
n_flag_in  input  1  status negative flag
ir_out  output  DATA_WIDTH  latched instruction register
pc_inc_out  output  1  PC <= PC+1
pc_load_out  output  1  PC <= ir_out[10:0]
mem_rd_out  output  1  data memory read, address ir_out[10:0]
mem_wr_out  output  1  data memory write of ACC
acc_load_out  output  1  ACC <= mux output
acc_sel_out  output  2  accumulator mux select: 00 memory data, 01 ALU result, 10 immediate
alu_op_out  output  1  0 add, 1 subtract
alu_src_out  output  1  ALU B operand: 0 memory data, 1 sign-extended immediate
halted_out  output  1  HLT executed
state_out  output  3  current state encoding, for debug

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE(000), IR=0. All outputs 0; acc_sel_out=00.
- Reset asserted mid-instruction aborts immediately. No partial write survives past the reset edge.
- States: IDLE=000, FETCH=001, DECODE=010, MEMRD=011, EXEC=100, HALT=101. Codes 110/111 recover to IDLE on the next clock.
- Control outputs are Moore decodes of the registered state and IR only. They never depend on instr_in or the flags, except pc_load_out/pc_inc_out in EXEC for branches.
- IDLE: all outputs 0. Go to FETCH when run_in=1.
- FETCH: IR <= instr_in at the clock edge. Next state DECODE.
- DECODE: no datapath strobes. Next state:
  - HLT 00000 -> HALT
  - LD 00010, ADD 00100, SUB 00110 -> MEMRD
  - all others -> EXEC
- MEMRD: mem_rd_out=1. Data is valid the next cycle. Next state EXEC.
- EXEC: exactly one cycle, then FETCH if run_in=1, else IDLE. run_in is sampled only here and in IDLE. Opcode actions:
  - STO 00001: mem_wr_out=1, pc_inc_out=1
  - LD 00010: acc_load_out=1, acc_sel_out=00, pc_inc_out=1
  - LDI 00011: acc_load_out=1, acc_sel_out=10, pc_inc_out=1
  - ADD 00100 / ADDI 00101: acc_load_out=1, acc_sel_out=01, alu_op_out=0, alu_src_out=0 for ADD / 1 for ADDI, pc_inc_out=1
  - SUB 00110 / SUBI 00111: as ADD/ADDI with alu_op_out=1
  - Branches: if the condition holds, pc_load_out=1; otherwise pc_inc_out=1. Conditions:
    - BEQ 01000: Z
    - BNE 01001: !Z
    - BGT 01010: !Z & !N
    - BGE 01011: !N
    - BLT 01100: N
    - BLE 01101: N | Z
  - JMP 01110: pc_load_out=1
  - Any undefined opcode: NOP, pc_inc_out=1 only.
- pc_load_out and pc_inc_out are never asserted together.
- HALT: halted_out=1, all other strobes 0. HALT is sticky; only reset exits it, and run_in is ignored.
- Latency in cycles, FETCH through EXEC: 3 for immediate/branch/STO/NOP, 4 for LD/ADD/SUB, 2 for HLT to reach HALT.
- Flags are sampled in the EXEC cycle. They reflect the ACC value written by any prior instruction.

Test Plan:
- Reset/idle: hold rst_n_in=0 for 2 cycles with run_in=1 -> state_out=000, all strobes 0. Release -> FETCH next edge, DECODE the following edge.
- LDI 5 (0x1805): run_in=1 -> EXEC cycle 3 shows acc_load_out=1, acc_sel_out=10, pc_inc_out=1. Back to FETCH.
- ADD 0x002 (0x2002) -> mem_rd_out=1 in MEMRD. Next cycle acc_sel_out=01, alu_op_out=0, alu_src_out=0, acc_load_out=1. Total 4 cycles. SUBI 3 (0x3803) -> alu_op_out=1, alu_src_out=1, 3 cycles.
- Branches: BEQ 0x010 (0x4010) with Z=1 -> pc_load_out=1, pc_inc_out=0. With Z=0 -> pc_inc_out=1. Sweep BGT/BLE over all four (Z,N) combinations.
- run_in drop: deassert during DECODE of STO (0x0804) -> mem_wr_out pulses once in EXEC, then state_out=000 and no further FETCH.
- HLT (0x0000) -> HALT within 2 cycles, halted_out=1 stays high with run_in toggling. Mid-EXEC async reset -> outputs 0 immediately, without waiting for a clock edge.
